pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
Central hazard and flow controller for the 5-stage MIPS pipeline. It computes the IF/ID freeze (`stall`), the ID/EX bubble (`E_flush`) and the global exception flush (`req`). It also sequences the multi-cycle MDU busy window with a cycle counter. Its outputs drive the stall/req inputs of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold.

Parameters:
MULT_CYCLES, 5, MDU busy cycles for mult/multu; legal range 1..2^CNT_W-1
DIV_CYCLES, 10, MDU busy cycles for div/divu; legal range 1..2^CNT_W-1
CNT_W, 4, width of the MDU down-counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
D_rs_addr  in  5  rs register number of the D-stage instruction
D_rt_addr  in  5  rt register number of the D-stage instruction
D_rs_tuse  in  2  cycles until D needs rs; 3 = not used
D_rt_tuse  in  2  cycles until D needs rt; 3 = not used
E_wa  in  5  destination register of the E-stage instruction; 0 = none
E_tnew  in  2  cycles until the E-stage result is ready, already stage-adjusted
M_wa  in  5  destination register of the M-stage instruction
M_tnew  in  2  cycles until the M-stage result is ready
D_mdu_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
E_mdu_start  in  1  E instruction launches an MDU operation this cycle
E_mdu_op  in  1  0 = mult class, 1 = div class
D_eret  in  1  D instruction is eret
E_mtc0_epc  in  1  E instruction is mtc0 to EPC
M_mtc0_epc  in  1  M instruction is mtc0 to EPC
int_req  in  1  CP0 exception/interrupt taken at M stage
stall  out  1  freeze the PC and IF/ID
E_flush  out  1  insert a bubble into ID/EX
req  out  1  flush all pipeline registers and redirect to 0x4180
mdu_busy  out  1  MDU sequencer is in BUSY
mdu_done  out  1  one-cycle pulse on the last busy cycle
stall_cnt  out  32  count of cycles with stall=1

Behaviour:
- Reset (reset==0 at a rising edge): state is IDLE, counter is 0, mdu_busy=0, mdu_done=0, stall_cnt=0. A reset mid-operation aborts BUSY in one edge.
- Combinational outputs while reset is low: stall=0, E_flush=0, req=0.
- rs data stall: `rs_stall = (D_rs_addr!=0) && ((D_rs_addr==E_wa && E_tnew>D_rs_tuse) || (D_rs_addr==M_wa && M_tnew>D_rs_tuse))`.
- rt data stall: `rt_stall` uses the same rule with the rt signals.
- MDU stall: `mdu_stall = D_mdu_use && (E_mdu_start || state==BUSY)`.
- eret stall: `eret_stall = D_eret && (E_mtc0_epc || M_mtc0_epc)`.
- Combined stall (combinational, no latency): `stall = (rs_stall | rt_stall | mdu_stall | eret_stall) & ~req`.
- E_flush equals stall.
- req equals int_req (combinational) while reset is high. req has priority: when req=1, stall=0 and E_flush=0.
- MDU FSM, two states, IDLE and BUSY:
  - IDLE -> BUSY when E_mdu_start && !req. Counter loads MULT_CYCLES if E_mdu_op==0, else DIV_CYCLES.
  - BUSY: the counter decrements by 1 each cycle.
  - When counter==1 in BUSY: mdu_done=1 for that cycle, and the next state is IDLE with counter 0.
  - E_mdu_start while in BUSY is ignored. The datapath cannot issue it, because mdu_stall holds D.
  - If int_req arrives during BUSY, the operation already launched completes normally; only a start in the same cycle as req is blocked.
- mdu_busy = (state==BUSY), registered. The result is held for exactly MULT_CYCLES/DIV_CYCLES cycles after the start edge.
- stall_cnt increments by 1 at each edge where stall==1 and reset is high. It wraps 0xFFFFFFFF -> 0.
- Width rules: tuse/tnew comparisons are unsigned 2-bit. Register 0 never causes a stall.

Test Plan:
- Load-use: set D_rs_addr=5, D_rs_tuse=0, E_wa=5, E_tnew=2 -> stall=1 and E_flush=1 the same cycle. Then set E_tnew=1, D_rs_tuse=1 -> stall=0. A case with D_rs_addr=0 and E_wa=0 -> stall=0.
- Mult busy: pulse E_mdu_start=1 with E_mdu_op=0 for 1 cycle, with D_mdu_use held at 1:
  - stall=1 on the start cycle plus 5 following cycles;
  - mdu_busy=1 for 5 cycles;
  - mdu_done pulses in the 5th busy cycle;
  - stall_cnt=6 afterwards.
- Div busy: pulse E_mdu_start with E_mdu_op=1 -> mdu_busy high for exactly 10 cycles. Additional E_mdu_start pulses during BUSY do not extend it.
- Exception priority: int_req=1 together with a load-use hazard and E_mdu_start=1 -> req=1, stall=0, E_flush=0, and the FSM stays IDLE. int_req during BUSY -> BUSY still counts down to done.
- eret: D_eret=1 with M_mtc0_epc=1 -> stall=1. Deassert M_mtc0_epc -> stall=0 the same cycle.
- Reset: drive reset=0 at busy count 3 -> next edge mdu_busy=0, mdu_done=0, stall_cnt=0. During reset=0, with int_req=1 -> req=0.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/flow-control bundle between pipeline decode/execute logic and pipe_stall_ctrl.
// master drives the stage-side hazard inputs; slave (the controller) returns stall/flush/req.
interface pipe_stall_ctrl_if;
  logic [4:0]  D_rs_addr;
  logic [4:0]  D_rt_addr;
  logic [1:0]  D_rs_tuse;
  logic [1:0]  D_rt_tuse;
  logic [4:0]  E_wa;
  logic [1:0]  E_tnew;
  logic [4:0]  M_wa;
  logic [1:0]  M_tnew;
  logic        D_mdu_use;
  logic        E_mdu_start;
  logic        E_mdu_op;
  logic        D_eret;
  logic        E_mtc0_epc;
  logic        M_mtc0_epc;
  logic        int_req;
  logic        stall;
  logic        E_flush;
  logic        req;
  logic        mdu_busy;
  logic        mdu_done;
  logic [31:0] stall_cnt;

  modport master (
    output D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, E_wa, E_tnew, M_wa, M_tnew,
           D_mdu_use, E_mdu_start, E_mdu_op, D_eret, E_mtc0_epc, M_mtc0_epc, int_req,
    input  stall, E_flush, req, mdu_busy, mdu_done, stall_cnt
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, E_wa, E_tnew, M_wa, M_tnew,
           D_mdu_use, E_mdu_start, E_mdu_op, D_eret, E_mtc0_epc, M_mtc0_epc, int_req,
    output stall, E_flush, req, mdu_busy, mdu_done, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: stall/E_flush/req are combinational (zero latency), MDU busy
// window and stall counter are registered. Exception req overrides stall; no backpressure input.
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic clk,
  input logic reset,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        stall_cnt_q;

  logic rs_stall, rt_stall, mdu_stall, eret_stall;
  logic req_w, stall_w;

  always_comb begin
    rs_stall   = (bus.D_rs_addr != 5'd0) &&
                 ((bus.D_rs_addr == bus.E_wa && bus.E_tnew > bus.D_rs_tuse) ||
                  (bus.D_rs_addr == bus.M_wa && bus.M_tnew > bus.D_rs_tuse));
    rt_stall   = (bus.D_rt_addr != 5'd0) &&
                 ((bus.D_rt_addr == bus.E_wa && bus.E_tnew > bus.D_rt_tuse) ||
                  (bus.D_rt_addr == bus.M_wa && bus.M_tnew > bus.D_rt_tuse));
    mdu_stall  = bus.D_mdu_use && (bus.E_mdu_start || state_q == BUSY);
    eret_stall = bus.D_eret && (bus.E_mtc0_epc || bus.M_mtc0_epc);
    // Everything is forced quiet while reset is held low.
    req_w      = reset && bus.int_req;
    stall_w    = reset && (rs_stall || rt_stall || mdu_stall || eret_stall) && !req_w;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_w) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  // A start coinciding with an exception is dropped; once BUSY, the operation always completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.E_mdu_start && !req_w) begin
          state_d = BUSY;
          cnt_d   = bus.E_mdu_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.stall     = stall_w;
    bus.E_flush   = stall_w;
    bus.req       = req_w;
    bus.mdu_busy  = (state_q == BUSY);
    bus.mdu_done  = (state_q == BUSY) && (cnt_q == CNT_W'(1));
    bus.stall_cnt = stall_cnt_q;
  end

endmodule
